// File: rtl/mem_ctrl_pkg.sv
// Shared types for the multi-port main_mem controller.
// Block addresses exclude the in-block byte offset.
package mem_ctrl_pkg;

    localparam int MAIN_MEM_ADDR_WIDTH         = 32;
    localparam int MAIN_MEM_BLOCK_OFFSET_WIDTH = 4;
    localparam int BLOCK_DATA_WIDTH            = 8 << MAIN_MEM_BLOCK_OFFSET_WIDTH;
    localparam int PORT_ID_MAX_W               = 8;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_type_t;

    typedef logic [MAIN_MEM_ADDR_WIDTH-MAIN_MEM_BLOCK_OFFSET_WIDTH-1:0] main_mem_block_addr_t;
    typedef logic [BLOCK_DATA_WIDTH-1:0] block_data_t;

    // port_id is sized for the largest supported port count; users truncate.
    typedef struct packed {
        logic [PORT_ID_MAX_W-1:0] port_id;
        req_type_t                req_type;
        main_mem_block_addr_t     addr;
        block_data_t              data;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr
// wins, otherwise the lowest requester overall.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    logic [N-1:0] req_hi;

    always_comb begin
        req_hi = '0;
        for (int i = 0; i < N; i++) begin
            req_hi[i] = req[i] && (i >= int'(ptr));
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((|req_hi) ? req_hi[i] : req[i]) begin
                gnt_idx = IW'(i);
            end
        end
        gnt = '0;
        if (|req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_ctrl_mp.sv
// N-port round-robin main_mem controller with read credits and tagged responses.
// Define MEM_CTRL_MP_STATS_EN to add per-port grant/stall counters.
module mem_ctrl_mp
    import mem_ctrl_pkg::*;
#(
    parameter int N_PORTS         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst_aH,
    input  logic [N_PORTS-1:0]           req_valid,
    input  req_type_t                    req_type [N_PORTS],
    input  main_mem_block_addr_t         req_block_addr [N_PORTS],
    input  block_data_t                  req_block_data [N_PORTS],
    output logic [N_PORTS-1:0]           req_ready,
    output logic [N_PORTS-1:0]           resp_valid,
    output block_data_t                  resp_block_data,
    output logic                         mem_req_valid,
    output logic [$clog2(N_PORTS)-1:0]   mem_req_port_id,
    output req_type_t                    mem_req_type,
    output main_mem_block_addr_t         mem_req_block_addr,
    output block_data_t                  mem_req_block_data,
    input  logic                         mem_resp_valid,
    input  logic [$clog2(N_PORTS)-1:0]   mem_resp_port_id,
    input  block_data_t                  mem_resp_block_data
`ifdef MEM_CTRL_MP_STATS_EN
    ,
    output logic [31:0]                  stat_grants [N_PORTS],
    output logic [31:0]                  stat_stalls [N_PORTS]
`endif
);

    localparam int PIW = $clog2(N_PORTS);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(MAX_OUTSTANDING);

    logic [N_PORTS-1:0] eligible;
    logic [N_PORTS-1:0] gnt;
    logic [PIW-1:0]     gnt_idx;
    logic               grant;
    logic               grant_rd;
    logic               resp_ok;

    logic [PIW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      credits_q, credits_d;
    mem_req_t           issue_q, issue_d;
    logic               issue_vld_q;
    logic [N_PORTS-1:0] resp_vld_q, resp_vld_d;
    block_data_t        resp_data_q;

    // Reset also masks grants so every output reads zero while it is held.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            eligible[p] = !rst_aH && req_valid[p]
                       && (req_type[p] == WRITE || credits_q != '0);
        end
    end

    rr_arbiter #(.N(N_PORTS)) u_arb (
        .req     (eligible),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign grant    = |gnt;
    assign grant_rd = grant && req_type[gnt_idx] == READ;
    // A full credit pool means nothing is in flight: the response is stale.
    assign resp_ok  = mem_resp_valid && credits_q != CRED_MAX;

    always_comb begin
        credits_d = credits_q;
        if (grant_rd && !resp_ok) begin
            credits_d = credits_q - 1'b1;
        end else if (!grant_rd && resp_ok) begin
            credits_d = credits_q + 1'b1;
        end

        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (int'(gnt_idx) == N_PORTS - 1) ? '0 : gnt_idx + 1'b1;
        end

        issue_d = issue_q;
        if (grant) begin
            issue_d.port_id  = PORT_ID_MAX_W'(gnt_idx);
            issue_d.req_type = req_type[gnt_idx];
            issue_d.addr     = req_block_addr[gnt_idx];
            issue_d.data     = req_block_data[gnt_idx];
        end

        // Tags outside the port range decode to no port at all.
        resp_vld_d = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            resp_vld_d[p] = resp_ok && (mem_resp_port_id == PIW'(p));
        end
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            rr_ptr_q    <= '0;
            credits_q   <= CRED_MAX;
            issue_q     <= '0;
            issue_vld_q <= 1'b0;
            resp_vld_q  <= '0;
            resp_data_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            credits_q   <= credits_d;
            issue_q     <= issue_d;
            issue_vld_q <= grant;
            resp_vld_q  <= resp_vld_d;
            if (|resp_vld_d) begin
                resp_data_q <= mem_resp_block_data;
            end
        end
    end

    assign req_ready          = gnt;
    assign resp_valid         = resp_vld_q;
    assign resp_block_data    = resp_data_q;
    assign mem_req_valid      = issue_vld_q;
    assign mem_req_port_id    = PIW'(issue_q.port_id);
    assign mem_req_type       = issue_q.req_type;
    assign mem_req_block_addr = issue_q.addr;
    assign mem_req_block_data = issue_q.data;

`ifdef MEM_CTRL_MP_STATS_EN
    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            for (int p = 0; p < N_PORTS; p++) begin
                stat_grants[p] <= '0;
                stat_stalls[p] <= '0;
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (gnt[p] && stat_grants[p] != '1) begin
                    stat_grants[p] <= stat_grants[p] + 1'b1;
                end
                if (req_valid[p] && !gnt[p] && stat_stalls[p] != '1) begin
                    stat_stalls[p] <= stat_stalls[p] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// Bench for mem_ctrl_mp: directed scenarios plus random traffic against
// a transaction-level model of arbitration, credits and response routing.
module tb_mem_ctrl_mp;
    import mem_ctrl_pkg::*;

    localparam int N    = 3;
    localparam int MAXO = 4;
    localparam int PIW  = $clog2(N);

    logic                 clk = 1'b0;
    logic                 rst_aH;
    logic [N-1:0]         req_valid;
    req_type_t            req_type [N];
    main_mem_block_addr_t req_block_addr [N];
    block_data_t          req_block_data [N];
    logic [N-1:0]         req_ready;
    logic [N-1:0]         resp_valid;
    block_data_t          resp_block_data;
    logic                 mem_req_valid;
    logic [PIW-1:0]       mem_req_port_id;
    req_type_t            mem_req_type;
    main_mem_block_addr_t mem_req_block_addr;
    block_data_t          mem_req_block_data;
    logic                 mem_resp_valid;
    logic [PIW-1:0]       mem_resp_port_id;
    block_data_t          mem_resp_block_data;
`ifdef MEM_CTRL_MP_STATS_EN
    logic [31:0]          stat_grants [N];
    logic [31:0]          stat_stalls [N];
    int                   m_grants [N];
    int                   m_stalls [N];
`endif

    mem_ctrl_mp #(.N_PORTS(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk                 (clk),
        .rst_aH              (rst_aH),
        .req_valid           (req_valid),
        .req_type            (req_type),
        .req_block_addr      (req_block_addr),
        .req_block_data      (req_block_data),
        .req_ready           (req_ready),
        .resp_valid          (resp_valid),
        .resp_block_data     (resp_block_data),
        .mem_req_valid       (mem_req_valid),
        .mem_req_port_id     (mem_req_port_id),
        .mem_req_type        (mem_req_type),
        .mem_req_block_addr  (mem_req_block_addr),
        .mem_req_block_data  (mem_req_block_data),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_port_id    (mem_resp_port_id),
        .mem_resp_block_data (mem_resp_block_data)
`ifdef MEM_CTRL_MP_STATS_EN
        ,
        .stat_grants         (stat_grants),
        .stat_stalls         (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model, evaluated mid-cycle for the coming edge.
    int                   m_ptr, m_cred, m_win, m_old, m_p;
    logic                 m_req_v = 1'b0;
    int                   m_req_pid;
    req_type_t            m_req_type;
    main_mem_block_addr_t m_req_addr;
    block_data_t          m_req_data;
    logic [N-1:0]         m_resp_v = '0;
    logic [N-1:0]         exp_rdy;
    block_data_t          m_resp_data;

    always @(negedge clk) begin
        if (rst_aH) begin
            m_ptr    = 0;
            m_cred   = MAXO;
            m_req_v  = 1'b0;
            m_resp_v = '0;
            chk("rst_req_ready", req_ready, '0);
            chk("rst_mem_req_valid", mem_req_valid, '0);
            chk("rst_resp_valid", resp_valid, '0);
`ifdef MEM_CTRL_MP_STATS_EN
            for (int p = 0; p < N; p++) begin
                m_grants[p] = 0;
                m_stalls[p] = 0;
            end
`endif
        end else begin
            exp_rdy = '0;
            m_win   = -1;
            for (int k = 0; k < N; k++) begin
                m_p = (m_ptr + k) % N;
                if (m_win < 0 && req_valid[m_p] && (req_type[m_p] == WRITE || m_cred > 0))
                    m_win = m_p;
            end
            if (m_win >= 0) exp_rdy[m_win] = 1'b1;

            chk("req_ready", req_ready, exp_rdy);
            chk("mem_req_valid", mem_req_valid, m_req_v);
            if (m_req_v) begin
                chk("mem_req_port_id", mem_req_port_id, m_req_pid);
                chk("mem_req_type", mem_req_type, m_req_type);
                chk("mem_req_addr", mem_req_block_addr, m_req_addr);
                chk("mem_req_data", mem_req_block_data, m_req_data);
            end
            chk("resp_valid", resp_valid, m_resp_v);
            if (m_resp_v != '0) chk("resp_data", resp_block_data, m_resp_data);

`ifdef MEM_CTRL_MP_STATS_EN
            for (int p = 0; p < N; p++) begin
                if (exp_rdy[p]) m_grants[p]++;
                if (req_valid[p] && !exp_rdy[p]) m_stalls[p]++;
            end
`endif
            m_old   = m_cred;
            m_req_v = (m_win >= 0);
            if (m_win >= 0) begin
                m_req_pid  = m_win;
                m_req_type = req_type[m_win];
                m_req_addr = req_block_addr[m_win];
                m_req_data = req_block_data[m_win];
                m_ptr      = (m_win + 1) % N;
                if (req_type[m_win] == READ) m_cred--;
            end
            m_resp_v = '0;
            if (mem_resp_valid && m_old != MAXO) begin
                m_cred++;
                if (int'(mem_resp_port_id) < N) begin
                    m_resp_v[mem_resp_port_id] = 1'b1;
                    m_resp_data = mem_resp_block_data;
                end
            end
        end
    end

    int           mq [$];
    logic [N-1:0] acc;
    logic [N-1:0] t2_exp [6];
    block_data_t  d1, d2;
    int           ids [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid           = '0;
        mem_resp_valid      = 1'b0;
        mem_resp_port_id    = '0;
        mem_resp_block_data = '0;
        for (int p = 0; p < N; p++) begin
            req_type[p]       = READ;
            req_block_addr[p] = main_mem_block_addr_t'(32'h100 + p);
            req_block_data[p] = block_data_t'(p);
        end
    endtask

    task automatic do_reset();
        rst_aH = 1'b1;
        idle_inputs();
        mq.delete();
        repeat (2) tick();
        rst_aH = 1'b0;
    endtask

    initial begin
        rst_aH = 1'b1;
        idle_inputs();
        d1 = {4{32'hDEAD_BEEF}};
        d2 = {4{32'h1234_5678}};
        t2_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000};
        ids = '{1, 2, 0, 0};
        repeat (2) tick();
        @(negedge clk);
        chk("reset_mem_req_addr", mem_req_block_addr, '0);
        chk("reset_resp_data", resp_block_data, '0);
        tick();
        rst_aH = 1'b0;

        // Single read from port 0 and its response.
        req_valid[0] = 1'b1;
        req_block_addr[0] = 28'h10;
        @(negedge clk);
        chk("t1_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_mem_valid", mem_req_valid, 1'b1);
        chk("t1_mem_pid", mem_req_port_id, 0);
        chk("t1_mem_addr", mem_req_block_addr, 28'h10);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_port_id = 2'd0;
        mem_resp_block_data = d1;
        @(negedge clk);
        chk("t1_mem_pulse", mem_req_valid, 1'b0);
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("t1_resp_valid", resp_valid, 3'b001);
        chk("t1_resp_data", resp_block_data, d1);
        tick();
        @(negedge clk);
        chk("t1_resp_pulse", resp_valid, 3'b000);

        // All ports read: round-robin until the credits run out.
        do_reset();
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t2_grant", req_ready, t2_exp[c]);
            tick();
        end

        // Writes bypass the empty credit pool; reads wait for a return.
        req_valid = 3'b011;
        req_type[1] = WRITE;
        req_block_addr[1] = 28'h200;
        @(negedge clk);
        chk("t3_write_grant", req_ready, 3'b010);
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("t3_read_stall", req_ready, 3'b000);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_port_id = 2'd0;
        mem_resp_block_data = d2;
        @(negedge clk);
        chk("t3_stall_on_resp", req_ready, 3'b000);
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("t3_read_after_credit", req_ready, 3'b001);
        chk("t3_resp_valid", resp_valid, 3'b001);
        chk("t3_resp_data", resp_block_data, d2);
        tick();
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_port_id = PIW'(ids[i]);
            mem_resp_block_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        mem_resp_valid = 1'b0;
        tick();

        // Reset with three reads in flight, then a stale response.
        req_valid[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_issue", req_ready, 3'b001);
            tick();
        end
        #2;
        rst_aH = 1'b1;
        #1;
        chk("t5_async_ready", req_ready, '0);
        chk("t5_async_mem_valid", mem_req_valid, '0);
        chk("t5_async_mem_addr", mem_req_block_addr, '0);
        chk("t5_async_resp", resp_valid, '0);
        req_valid = '0;
        tick();
        rst_aH = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_port_id = 2'd0;
        tick();
        mem_resp_valid = 1'b0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("t5_stale_dropped", resp_valid, '0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("t5_credits", req_ready[0], c < 4);
            tick();
        end

        // Out-of-range tag: no port response, credit still returned.
        mem_resp_valid = 1'b1;
        mem_resp_port_id = 2'd3;
        @(negedge clk);
        chk("bad_id_stall", req_ready, 3'b000);
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("bad_id_credit", req_ready, 3'b001);
        chk("bad_id_no_resp", resp_valid, 3'b000);
        tick();
        req_valid = '0;

        // Random traffic with an in-order main_mem responder.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_ready;
            if (mem_req_valid && mem_req_type == READ) mq.push_back(int'(mem_req_port_id));
            tick();
            for (int p = 0; p < N; p++) begin
                if (!(req_valid[p] && !acc[p] && $urandom_range(0, 9) != 0)) begin
                    req_valid[p]      = $urandom_range(0, 2) != 0;
                    req_type[p]       = ($urandom_range(0, 3) == 0) ? WRITE : READ;
                    req_block_addr[p] = main_mem_block_addr_t'($urandom);
                    req_block_data[p] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            mem_resp_valid = 1'b0;
            if (mq.size() > 0 && $urandom_range(0, 2) == 0) begin
                mem_resp_valid      = 1'b1;
                mem_resp_port_id    = PIW'(mq.pop_front());
                mem_resp_block_data = {$urandom, $urandom, $urandom, $urandom};
            end else if (mq.size() == 0 && $urandom_range(0, 15) == 0) begin
                mem_resp_valid      = 1'b1;
                mem_resp_port_id    = PIW'($urandom_range(0, 3));
                mem_resp_block_data = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        req_valid = '0;
        mem_resp_valid = 1'b0;
        tick();
        @(negedge clk);
`ifdef MEM_CTRL_MP_STATS_EN
        for (int p = 0; p < N; p++) begin
            chk("stat_grants", stat_grants[p], m_grants[p]);
            chk("stat_stalls", stat_stalls[p], m_stalls[p]);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
